mem_request_sequencer: RTL and testbench
========================================

MEM_REQUEST_SEQUENCER -- requirements
Module: mem_request_sequencer

Interface
REQ-001 SHALL have parameter SIZE_WIDTH, default 16, width of request and response byte-size fields.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of the timestamp, latency-sum and max-latency counters.
REQ-003 SHALL have parameter DEPTH, default 4, maximum number of outstanding requests; power of 2, minimum 2.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; ports as follows.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse that begins a run; ignored unless state is IDLE or DONE.
REQ-008 cfg_num_reqs  input  16  number of requests in the run; sampled on the accepted start.
REQ-009 cfg_pattern  input  2  request type sequence: 0 all SRAM, 1 all DRAM, 2 alternate starting with SRAM, 3 alternate starting with DRAM; sampled on start.
REQ-010 cfg_sram_size / cfg_dram_size  input  SIZE_WIDTH each  byte size for SRAM and DRAM requests respectively; sampled on start.
REQ-011 req_valid, req_is_dram, req_size_bytes  output  1/1/SIZE_WIDTH  request to the memory latency injector.
REQ-012 req_ready  input  1  injector accepts a request; a handshake occurs when req_valid and req_ready are both high.
REQ-013 resp_valid, resp_size_bytes  input  1/SIZE_WIDTH  in-order response from the injector.
REQ-014 busy, done  output  1 each  busy is high in ISSUE and DRAIN; done is high in DONE.
REQ-015 issued_cnt, resp_cnt  output  16 each  handshaken requests and matched responses in the current run.
REQ-016 sram_lat_sum, dram_lat_sum, max_lat  output  CNT_WIDTH each  latency statistics.
REQ-017 err_unexpected_resp, err_size_mismatch  output  1 each  sticky error flags.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, DRAIN and DONE with these transitions: IDLE/DONE to ISSUE on start; if cfg_num_reqs is 0, IDLE/DONE go directly to DONE instead. ISSUE to DRAIN in the cycle the final handshake occurs. DRAIN to DONE on the cycle after the response that empties the FIFO.
REQ-019 An accepted start SHALL clear the counters, sums, max_lat and error flags.
REQ-020 The type of request k (k counting from 0) SHALL follow cfg_pattern; for patterns 2 and 3, k[0] selects the alternating type. Size SHALL be cfg_dram_size for DRAM requests and cfg_sram_size for SRAM requests.
REQ-021 Request outputs SHALL be registered; once req_valid is high, req_valid and payload SHALL stay stable until the handshake.
REQ-022 On a handshake, the next request SHALL be presented on the following cycle if one remains and the FIFO is not full; this allows back-to-back issue when req_ready is held high.
REQ-023 req_valid SHALL be low when the FIFO holds DEPTH entries; the occupancy check SHALL count a pop in the same cycle, so a simultaneous response frees the slot.
REQ-024 Free-running timestamp counter: CNT_WIDTH bits, reset to 0, wraps modulo 2^CNT_WIDTH.
REQ-025 On each handshake, the block SHALL push {is_dram, size, timestamp} into the in-flight FIFO and increment issued_cnt.
REQ-026 On resp_valid with a non-empty FIFO, the block SHALL pop the head and compute latency = timestamp - head.timestamp, modulo 2^CNT_WIDTH, so a response in the cycle after the handshake has latency 1.
REQ-027 The latency SHALL be added to sram_lat_sum or dram_lat_sum according to head.is_dram; sums saturate at all-ones.
REQ-028 max_lat SHALL be updated to the maximum latency observed so far.
REQ-029 Each popped response SHALL increment resp_cnt.
REQ-030 If resp_size_bytes differs from head.size, err_size_mismatch SHALL be set; the response is still counted.
REQ-031 resp_valid with an empty FIFO, in any state, SHALL set err_unexpected_resp and leave the FIFO and statistics unchanged.
REQ-032 A push and a pop in the same cycle SHALL both take effect, with occupancy unchanged.
REQ-033 Outputs SHALL hold their final values in DONE until the next accepted start.

Reset
REQ-034 On reset assertion, the block SHALL asynchronously enter IDLE, empty the FIFO, and drive req_valid=0, req_is_dram=0, req_size_bytes=0, busy=0 and done=0.
REQ-035 On reset, all counters, sums, max_lat, the timestamp counter and both error flags SHALL be 0.
REQ-036 Reset asserted mid-run SHALL abandon the run; no response is matched after release until a new start.

Verification
REQ-037 num=8, pattern=2, sizes 64/128, injector fixed at 5/10 cycles, one outstanding -> issued_cnt=8, resp_cnt=8, sram_lat_sum=4*L_s, dram_lat_sum=4*L_d, where L_s and L_d are the measured per-type latencies; done=1.
REQ-038 DEPTH=4, req_ready held high, responses withheld -> exactly 4 handshakes, then req_valid=0; one resp_valid pulse -> a fifth handshake on the next cycle.
REQ-039 resp_valid pulsed in IDLE -> err_unexpected_resp=1; resp_cnt=0.
REQ-040 Response size 100 against expected 64 -> err_size_mismatch=1, resp_cnt incremented, run completes.
REQ-041 cfg_num_reqs=0 start -> done=1 on the next cycle; req_valid never high.
REQ-042 Reset pulsed during DRAIN with 2 outstanding -> all outputs 0; a later start with num=2 completes with resp_cnt=2.

Source files
------------

// File: rtl/mem_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_request_sequencer
// Description : Issues a configured run of SRAM/DRAM requests. Tracks the
//               in-flight requests in order and collects latency statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_request_sequencer #(
    parameter int SIZE_WIDTH = 16,
    parameter int CNT_WIDTH  = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [15:0]           cfg_num_reqs,
    input  logic [1:0]            cfg_pattern,
    input  logic [SIZE_WIDTH-1:0] cfg_sram_size,
    input  logic [SIZE_WIDTH-1:0] cfg_dram_size,
    output logic                  req_valid,
    output logic                  req_is_dram,
    output logic [SIZE_WIDTH-1:0] req_size_bytes,
    input  logic                  req_ready,
    input  logic                  resp_valid,
    input  logic [SIZE_WIDTH-1:0] resp_size_bytes,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           issued_cnt,
    output logic [15:0]           resp_cnt,
    output logic [CNT_WIDTH-1:0]  sram_lat_sum,
    output logic [CNT_WIDTH-1:0]  dram_lat_sum,
    output logic [CNT_WIDTH-1:0]  max_lat,
    output logic                  err_unexpected_resp,
    output logic                  err_size_mismatch
);

    localparam int               c_PTR_W    = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL     = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_PTR_W:0] c_ONE      = (c_PTR_W + 1)'(1);
    localparam logic [1:0]       c_ST_IDLE  = 2'd0;
    localparam logic [1:0]       c_ST_ISSUE = 2'd1;
    localparam logic [1:0]       c_ST_DRAIN = 2'd2;
    localparam logic [1:0]       c_ST_DONE  = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;

    logic [15:0]           r_num;
    logic [1:0]            r_pattern;
    logic [SIZE_WIDTH-1:0] r_sram_size;
    logic [SIZE_WIDTH-1:0] r_dram_size;

    logic                  r_req_valid;
    logic                  r_req_is_dram;
    logic [SIZE_WIDTH-1:0] r_req_size;

    logic [CNT_WIDTH-1:0]  r_ts;
    logic [15:0]           r_issued;
    logic [15:0]           r_resp;
    logic [CNT_WIDTH-1:0]  r_sram_sum;
    logic [CNT_WIDTH-1:0]  r_dram_sum;
    logic [CNT_WIDTH-1:0]  r_max;
    logic                  r_err_unexp;
    logic                  r_err_size;

    logic                  r_mem_dram [DEPTH];
    logic [SIZE_WIDTH-1:0] r_mem_size [DEPTH];
    logic [CNT_WIDTH-1:0]  r_mem_ts   [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W:0]      r_count;

    logic                  w_start_ok;
    logic                  w_hs;
    logic                  w_pop;
    logic                  w_unexp;
    logic                  w_hold;
    logic                  w_last_hs;
    logic [15:0]           w_issued_nxt;
    logic [c_PTR_W:0]      w_count_nxt;
    logic                  w_nxt_valid;
    logic                  w_nxt_is_dram;
    logic [SIZE_WIDTH-1:0] w_nxt_size;
    logic                  w_start_is_dram;
    logic [CNT_WIDTH-1:0]  w_lat;
    logic [CNT_WIDTH:0]    w_sram_add;
    logic [CNT_WIDTH:0]    w_dram_add;

    function automatic logic f_is_dram(input logic [1:0] pat, input logic k0);
        case (pat)
            2'd0:    return 1'b0;
            2'd1:    return 1'b1;
            2'd2:    return k0;
            default: return ~k0;
        endcase
    endfunction

    assign w_start_ok   = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
    assign w_hs         = r_req_valid && req_ready;
    assign w_pop        = resp_valid && (r_count != '0);
    assign w_unexp      = resp_valid && (r_count == '0);
    assign w_hold       = r_req_valid && !req_ready;
    assign w_issued_nxt = r_issued + 16'(w_hs);
    assign w_last_hs    = w_hs && (w_issued_nxt == r_num);
    // Occupancy after this edge, so a same-cycle response frees a slot.
    assign w_count_nxt  = r_count + (c_PTR_W + 1)'(w_hs) - (c_PTR_W + 1)'(w_pop);

    assign w_nxt_valid     = (r_state == c_ST_ISSUE) && (w_issued_nxt < r_num) && (w_count_nxt < c_FULL);
    assign w_nxt_is_dram   = f_is_dram(r_pattern, w_issued_nxt[0]);
    assign w_nxt_size      = w_nxt_is_dram ? r_dram_size : r_sram_size;
    assign w_start_is_dram = f_is_dram(cfg_pattern, 1'b0);

    assign w_lat      = r_ts - r_mem_ts[r_rd_ptr];
    assign w_sram_add = {1'b0, r_sram_sum} + {1'b0, w_lat};
    assign w_dram_add = {1'b0, r_dram_sum} + {1'b0, w_lat};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
                if (start) begin
                    w_state_nxt = (cfg_num_reqs == 16'd0) ? c_ST_DONE : c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                if (w_last_hs) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_pop && (r_count == c_ONE)) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_valid   <= 1'b0;
            r_req_is_dram <= 1'b0;
            r_req_size    <= '0;
        end else if (w_start_ok) begin
            r_req_valid   <= (cfg_num_reqs != 16'd0);
            r_req_is_dram <= w_start_is_dram;
            r_req_size    <= w_start_is_dram ? cfg_dram_size : cfg_sram_size;
        end else if (!w_hold) begin
            r_req_valid   <= w_nxt_valid;
            r_req_is_dram <= w_nxt_is_dram;
            r_req_size    <= w_nxt_size;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    // Entry storage needs no reset: the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_mem_dram[r_wr_ptr] <= r_req_is_dram;
            r_mem_size[r_wr_ptr] <= r_req_size;
            r_mem_ts[r_wr_ptr]   <= r_ts;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num       <= '0;
            r_pattern   <= '0;
            r_sram_size <= '0;
            r_dram_size <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_issued    <= '0;
            r_resp      <= '0;
            r_sram_sum  <= '0;
            r_dram_sum  <= '0;
            r_max       <= '0;
            r_err_unexp <= 1'b0;
            r_err_size  <= 1'b0;
        end else if (w_start_ok) begin
            r_num       <= cfg_num_reqs;
            r_pattern   <= cfg_pattern;
            r_sram_size <= cfg_sram_size;
            r_dram_size <= cfg_dram_size;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_issued    <= '0;
            r_resp      <= '0;
            r_sram_sum  <= '0;
            r_dram_sum  <= '0;
            r_max       <= '0;
            r_err_unexp <= 1'b0;
            r_err_size  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            if (w_hs) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_issued <= w_issued_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_resp   <= r_resp + 16'd1;
                if (r_mem_dram[r_rd_ptr]) begin
                    r_dram_sum <= w_dram_add[CNT_WIDTH] ? '1 : w_dram_add[CNT_WIDTH-1:0];
                end else begin
                    r_sram_sum <= w_sram_add[CNT_WIDTH] ? '1 : w_sram_add[CNT_WIDTH-1:0];
                end
                if (w_lat > r_max) begin
                    r_max <= w_lat;
                end
                if (resp_size_bytes != r_mem_size[r_rd_ptr]) begin
                    r_err_size <= 1'b1;
                end
            end
            if (w_unexp) begin
                r_err_unexp <= 1'b1;
            end
        end
    end

    assign req_valid           = r_req_valid;
    assign req_is_dram         = r_req_is_dram;
    assign req_size_bytes      = r_req_size;
    assign busy                = (r_state == c_ST_ISSUE) || (r_state == c_ST_DRAIN);
    assign done                = (r_state == c_ST_DONE);
    assign issued_cnt          = r_issued;
    assign resp_cnt            = r_resp;
    assign sram_lat_sum        = r_sram_sum;
    assign dram_lat_sum        = r_dram_sum;
    assign max_lat             = r_max;
    assign err_unexpected_resp = r_err_unexp;
    assign err_size_mismatch   = r_err_size;

endmodule
`default_nettype wire

// File: tb/tb_mem_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_request_sequencer
// Description : Directed and randomized runs against a queue-based model of
//               the sequencer's request, in-flight and statistics rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_request_sequencer;

    localparam int              SIZE_WIDTH = 16;
    localparam int              CNT_WIDTH  = 32;
    localparam int              DEPTH      = 4;
    localparam longint unsigned c_CNT_MAX  = 64'hFFFF_FFFF;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  start = 1'b0;
    logic [15:0]           cfg_num_reqs = '0;
    logic [1:0]            cfg_pattern = '0;
    logic [SIZE_WIDTH-1:0] cfg_sram_size = '0;
    logic [SIZE_WIDTH-1:0] cfg_dram_size = '0;
    logic                  req_valid;
    logic                  req_is_dram;
    logic [SIZE_WIDTH-1:0] req_size_bytes;
    logic                  req_ready = 1'b0;
    logic                  resp_valid = 1'b0;
    logic [SIZE_WIDTH-1:0] resp_size_bytes = '0;
    logic                  busy;
    logic                  done;
    logic [15:0]           issued_cnt;
    logic [15:0]           resp_cnt;
    logic [CNT_WIDTH-1:0]  sram_lat_sum;
    logic [CNT_WIDTH-1:0]  dram_lat_sum;
    logic [CNT_WIDTH-1:0]  max_lat;
    logic                  err_unexpected_resp;
    logic                  err_size_mismatch;

    always #5 clk = ~clk;

    mem_request_sequencer #(
        .SIZE_WIDTH (SIZE_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH),
        .DEPTH      (DEPTH)
    ) u_dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .cfg_num_reqs        (cfg_num_reqs),
        .cfg_pattern         (cfg_pattern),
        .cfg_sram_size       (cfg_sram_size),
        .cfg_dram_size       (cfg_dram_size),
        .req_valid           (req_valid),
        .req_is_dram         (req_is_dram),
        .req_size_bytes      (req_size_bytes),
        .req_ready           (req_ready),
        .resp_valid          (resp_valid),
        .resp_size_bytes     (resp_size_bytes),
        .busy                (busy),
        .done                (done),
        .issued_cnt          (issued_cnt),
        .resp_cnt            (resp_cnt),
        .sram_lat_sum        (sram_lat_sum),
        .dram_lat_sum        (dram_lat_sum),
        .max_lat             (max_lat),
        .err_unexpected_resp (err_unexpected_resp),
        .err_size_mismatch   (err_size_mismatch)
    );

    typedef struct {
        bit              is_dram;
        int unsigned     size;
        longint unsigned ts;
    } ent_t;

    // Model: run phase 0 idle, 1 issuing, 2 draining, 3 finished.
    ent_t            q[$];
    int              m_phase;
    bit              m_valid, m_dram;
    int unsigned     m_size, m_issued, m_resp, m_num, m_pat, m_ssz, m_dsz;
    longint unsigned m_ts, m_ssum, m_dsum, m_max;
    bit              m_eu, m_es;
    int              tests = 0;
    int              fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned sat(input longint unsigned v);
        return (v > c_CNT_MAX) ? c_CNT_MAX : v;
    endfunction

    function automatic bit type_of(input int unsigned pat, input int unsigned k);
        case (pat)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (k % 2) == 1;
            default: return (k % 2) == 0;
        endcase
    endfunction

    task automatic present(input int unsigned k);
        m_dram = type_of(m_pat, k);
        m_size = m_dram ? m_dsz : m_ssz;
    endtask

    task automatic clear_stats();
        q.delete();
        m_valid = 0; m_dram = 0; m_size = 0;
        m_issued = 0; m_resp = 0;
        m_ssum = 0; m_dsum = 0; m_max = 0;
        m_eu = 0; m_es = 0;
    endtask

    task automatic model_reset();
        clear_stats();
        m_phase = 0; m_ts = 0;
        m_num = 0; m_pat = 0; m_ssz = 0; m_dsz = 0;
    endtask

    task automatic model_edge();
        bit              hs, pop;
        ent_t            h;
        longint unsigned lat;
        hs  = m_valid && req_ready;
        pop = resp_valid && (q.size() > 0);
        if (start && (m_phase == 0 || m_phase == 3)) begin
            clear_stats();
            m_num = cfg_num_reqs; m_pat = cfg_pattern;
            m_ssz = cfg_sram_size; m_dsz = cfg_dram_size;
            if (m_num == 0) begin
                m_phase = 3;
            end else begin
                m_phase = 1;
                present(0);
                m_valid = 1;
            end
        end else begin
            if (resp_valid && q.size() == 0) m_eu = 1;
            if (pop) begin
                h   = q.pop_front();
                lat = (m_ts - h.ts) & c_CNT_MAX;
                if (h.is_dram) m_dsum = sat(m_dsum + lat);
                else           m_ssum = sat(m_ssum + lat);
                if (lat > m_max) m_max = lat;
                m_resp++;
                if (resp_size_bytes != h.size) m_es = 1;
            end
            if (hs) begin
                q.push_back('{is_dram: m_dram, size: m_size, ts: m_ts});
                m_issued++;
            end
            if (m_phase == 1) begin
                if (hs && m_issued == m_num) m_phase = 2;
                if (!(m_valid && !req_ready)) begin
                    m_valid = (m_issued < m_num) && (q.size() < DEPTH);
                    if (m_valid) present(m_issued);
                end
            end else if (m_phase == 2 && pop && q.size() == 0) begin
                m_phase = 3;
            end
        end
        m_ts = (m_ts + 1) & c_CNT_MAX;
    endtask

    task automatic check_outputs();
        chk("req_valid", req_valid, m_valid);
        if (m_valid) begin
            chk("req_is_dram", req_is_dram, m_dram);
            chk("req_size", req_size_bytes, m_size);
        end
        chk("busy", busy, (m_phase == 1 || m_phase == 2));
        chk("done", done, (m_phase == 3));
        chk("issued_cnt", issued_cnt, m_issued);
        chk("resp_cnt", resp_cnt, m_resp);
        chk("sram_lat_sum", sram_lat_sum, m_ssum);
        chk("dram_lat_sum", dram_lat_sum, m_dsum);
        chk("max_lat", max_lat, m_max);
        chk("err_unexp", err_unexpected_resp, m_eu);
        chk("err_size", err_size_mismatch, m_es);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
        check_outputs();
        start      = 1'b0;
        resp_valid = 1'b0;
    endtask

    // mode 0: one outstanding, fixed 5/10-cycle latency; mode 1: random traffic.
    task automatic inj(input int mode, input int bad);
        if (mode == 0) begin
            req_ready  = (q.size() == 0);
            resp_valid = (q.size() > 0) && ((m_ts - q[0].ts) >= (q[0].is_dram ? 10 : 5));
            resp_size_bytes = (q.size() == 0) ? '0 : (bad != 0) ? 16'd100 : 16'(q[0].size);
        end else begin
            req_ready  = ($urandom_range(0, 99) < 60);
            resp_valid = ($urandom_range(0, 99) < 40);
            if (q.size() > 0 && $urandom_range(0, 99) >= bad) resp_size_bytes = 16'(q[0].size);
            else resp_size_bytes = 16'($urandom_range(0, 65535));
        end
    endtask

    task automatic start_run(input int num, input int pat, input int ss, input int ds);
        cfg_num_reqs  = 16'(num);
        cfg_pattern   = 2'(pat);
        cfg_sram_size = 16'(ss);
        cfg_dram_size = 16'(ds);
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        start         = 1'b1;
        cycle();
    endtask

    task automatic run_until_done(input int mode, input int bad, input int budget);
        int n = 0;
        while (m_phase != 3 && n < budget) begin
            inj(mode, bad);
            cycle();
            n++;
        end
        req_ready = 1'b0;
        chk("run_done", done, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_outputs();
        chk("rst_req_size", req_size_bytes, 0);
        chk("rst_req_is_dram", req_is_dram, 0);

        // Response with nothing in flight while idle.
        resp_valid = 1'b1;
        resp_size_bytes = 16'd64;
        cycle();
        chk("unexp_idle_flag", err_unexpected_resp, 1);
        chk("unexp_idle_resp_cnt", resp_cnt, 0);

        // Zero-length run finishes immediately without issuing.
        start_run(0, 0, 64, 128);
        chk("zero_done", done, 1);
        repeat (3) begin
            cycle();
            chk("zero_no_valid", req_valid, 0);
        end

        // Alternating run, one outstanding, fixed latencies.
        start_run(8, 2, 64, 128);
        run_until_done(0, 0, 600);
        chk("alt_issued", issued_cnt, 8);
        chk("alt_resp", resp_cnt, 8);
        chk("alt_sram_sum", sram_lat_sum, 4 * 5);
        chk("alt_dram_sum", dram_lat_sum, 4 * 10);
        chk("alt_max", max_lat, 10);
        repeat (2) cycle();
        chk("alt_hold_resp", resp_cnt, 8);

        // FIFO fills with responses withheld, then one response frees a slot.
        start_run(6, 0, 64, 128);
        req_ready = 1'b1;
        repeat (8) cycle();
        chk("full_issued", issued_cnt, 4);
        chk("full_valid_low", req_valid, 0);
        resp_valid = 1'b1;
        resp_size_bytes = 16'd64;
        cycle();
        chk("refill_valid", req_valid, 1);
        cycle();
        chk("fifth_hs", issued_cnt, 5);
        run_until_done(1, 0, 3000);

        // Wrong response size is flagged but still counted.
        start_run(3, 0, 64, 128);
        run_until_done(0, 1, 300);
        chk("mismatch_flag", err_size_mismatch, 1);
        chk("mismatch_resp_cnt", resp_cnt, 3);

        // Reset while draining two outstanding requests.
        start_run(2, 1, 64, 128);
        req_ready = 1'b1;
        repeat (3) cycle();
        chk("drain_busy", busy, 1);
        req_ready = 1'b0;
        #2 reset = 1'b1;
        #1 model_reset();
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
        resp_valid = 1'b1;
        resp_size_bytes = 16'd128;
        cycle();
        chk("post_rst_unexp", err_unexpected_resp, 1);
        chk("post_rst_resp_cnt", resp_cnt, 0);
        start_run(2, 2, 64, 128);
        run_until_done(0, 0, 300);
        chk("post_rst_run_resp", resp_cnt, 2);

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            start_run($urandom_range(1, 12), $urandom_range(0, 3),
                      $urandom_range(1, 4096), $urandom_range(1, 4096));
            run_until_done(1, 10, 3000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
